// File: rtl/booths_pkg.sv
// rtl/booths_pkg.sv - shared widths and FSM state type for the Booth multiplier/divider pair
package booths_pkg;

    localparam int W    = 8;
    localparam int DW   = 2 * W;
    localparam int ITER = 2 * W;
    localparam int CW   = $clog2(ITER);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration on operand magnitudes
module div_step
    import booths_pkg::*;
(
    input  logic [W:0]    rem,
    input  logic [DW-1:0] quo,
    input  logic [W-1:0]  b_mag,
    output logic [W:0]    rem_next,
    output logic [DW-1:0] quo_next
);

    logic [W+1:0] rem_sh;
    logic [W+1:0] b_ext;
    logic         borrow;

    always_comb begin
        rem_sh = {rem, quo[DW-1]};
        b_ext  = {2'b00, b_mag};
        borrow = (rem_sh < b_ext);
        // A failed trial leaves the shifted remainder untouched (the "restore").
        rem_next = borrow ? rem_sh[W:0] : (W+1)'(rem_sh - b_ext);
        quo_next = {quo[DW-2:0], ~borrow};
    end

endmodule

// File: rtl/booths_divider.sv
// rtl/booths_divider.sv - sequential signed 16/8 divider with start/done level handshake
module booths_divider
    import booths_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [DW-1:0]   A,
    input  logic [W-1:0]    B,
    input  logic            start,
    output logic            done,
    output logic [W-1:0]    Q,
    output logic [W-1:0]    R,
    output logic            ovf,
    output logic            dz
);

    localparam logic signed [DW:0] QMAX = (DW+1)'(127);
    localparam logic signed [DW:0] QMIN = -(DW+1)'(128);

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [DW-1:0]   quo_q, quo_d;
    logic [W:0]      rem_q, rem_d;
    logic [W-1:0]    b_mag_q, b_mag_d;
    logic            a_neg_q, a_neg_d;
    logic            b_neg_q, b_neg_d;
    logic            zero_q, zero_d;
    logic            done_q, done_d;
    logic [W-1:0]    q_q, q_d;
    logic [W-1:0]    r_q, r_d;
    logic            ovf_q, ovf_d;
    logic            dz_q, dz_d;

    logic [W:0]        rem_next;
    logic [DW-1:0]     quo_next;
    logic [DW-1:0]     a_mag;
    logic [W-1:0]      b_mag;
    logic signed [DW:0] q_full;

    div_step u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .b_mag    (b_mag_q),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    always_comb begin
        // 16-bit unsigned magnitude keeps |-32768| = 32768 exact.
        a_mag  = A[DW-1] ? (~A + 1'b1) : A;
        b_mag  = B[W-1]  ? (~B + 1'b1) : B;
        q_full = (a_neg_q ^ b_neg_q) ? -$signed({1'b0, quo_q}) : $signed({1'b0, quo_q});
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        b_mag_d = b_mag_q;
        a_neg_d = a_neg_q;
        b_neg_d = b_neg_q;
        zero_d  = zero_q;
        done_d  = done_q;
        q_d     = q_q;
        r_d     = r_q;
        ovf_d   = ovf_q;
        dz_d    = dz_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_neg_d = A[DW-1];
                    b_neg_d = B[W-1];
                    quo_d   = a_mag;
                    rem_d   = '0;
                    b_mag_d = b_mag;
                    zero_d  = (B == '0);
                    count_d = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                quo_d   = quo_next;
                rem_d   = rem_next;
                count_d = count_q + 1'b1;
                if (count_q == CW'(ITER - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (zero_q) begin
                    q_d   = '0;
                    r_d   = '0;
                    ovf_d = 1'b0;
                    dz_d  = 1'b1;
                end else begin
                    q_d   = q_full[W-1:0];
                    r_d   = W'(a_neg_q ? -rem_q : rem_q);
                    ovf_d = (q_full > QMAX) || (q_full < QMIN);
                    dz_d  = 1'b0;
                end
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (!start) begin
                    done_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            b_mag_q <= '0;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            b_mag_q <= b_mag_d;
            a_neg_q <= a_neg_d;
            b_neg_q <= b_neg_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
            q_q     <= q_d;
            r_q     <= r_d;
            ovf_q   <= ovf_d;
            dz_q    <= dz_d;
        end
    end

    assign done = done_q;
    assign Q    = q_q;
    assign R    = r_q;
    assign ovf  = ovf_q;
    assign dz   = dz_q;

endmodule

// File: tb/tb_booths_divider.sv
// tb/tb_booths_divider.sv - scoreboard bench for booths_divider with directed vectors
module tb_booths_divider;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] A;
    logic [7:0]  B;
    logic        start;
    logic        done;
    logic [7:0]  Q;
    logic [7:0]  R;
    logic        ovf;
    logic        dz;

    booths_divider dut (
        .clk   (clk),
        .reset (reset),
        .A     (A),
        .B     (B),
        .start (start),
        .done  (done),
        .Q     (Q),
        .R     (R),
        .ovf   (ovf),
        .dz    (dz)
    );

    always #5 clk = ~clk;

    typedef struct {
        int q;
        int r;
        int ovf;
        int dz;
        int cap;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    logic done_prev = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: on each rising done, pop the oldest expectation and compare.
    always @(negedge clk) begin
        if (!reset && done && !done_prev) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                check("latency", cyc - e.cap, 17);
                check("Q", int'(Q), e.q);
                check("R", int'(R), e.r);
                check("ovf", int'(ovf), e.ovf);
                check("dz", int'(dz), e.dz);
            end
        end
        done_prev = done;
    end

    // Called at a negedge with the DUT in IDLE; returns at a negedge in IDLE.
    task automatic run_op(input int a, input int b, input int eq, input int er,
                          input int eovf, input int edz, input int hold, input bit junk);
        int n;
        A     = 16'(a);
        B     = 8'(b);
        start = 1'b1;
        sb.push_back('{eq, er, eovf, edz, cyc + 1});
        @(negedge clk);
        if (junk) begin
            for (int i = 0; i < 10; i++) begin
                start = 1'($urandom_range(0, 1));
                A     = 16'($urandom);
                B     = 8'($urandom);
                @(negedge clk);
            end
            start = 1'b1;
        end
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got done=0 expected done=1 within 40 cycles (a=%0d b=%0d)", a, b);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_done", int'(done), 1);
            check("hold_Q", int'(Q), eq);
            check("hold_R", int'(R), er);
        end
        start = 1'b0;
        @(negedge clk);
        check("release_done", int'(done), 0);
        check("release_Q", int'(Q), eq);
        check("release_R", int'(R), er);
        check("release_ovf", int'(ovf), eovf);
        check("release_dz", int'(dz), edz);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        repeat (2) @(negedge clk);
        check("reset_done", int'(done), 0);
        check("reset_Q", int'(Q), 0);
        check("reset_R", int'(R), 0);
        check("reset_ovf", int'(ovf), 0);
        check("reset_dz", int'(dz), 0);
        reset = 1'b0;

        run_op(100, 7, 8'h0E, 8'h02, 0, 0, 2, 1'b0);

        run_op(-100,  7, 8'hF2, 8'hFE, 0, 0, 0, 1'b0);
        run_op( 100, -7, 8'hF2, 8'h02, 0, 0, 0, 1'b0);
        run_op(-100, -7, 8'h0E, 8'hFE, 0, 0, 0, 1'b0);
        run_op( -14,  7, 8'hFE, 8'h00, 0, 0, 0, 1'b0);

        run_op( 16384, -128, 8'h80, 8'h00, 0, 0, 0, 1'b0);
        run_op(-16256, -128, 8'h7F, 8'h00, 0, 0, 0, 1'b0);
        run_op(-16384, -128, 8'h80, 8'h00, 1, 0, 0, 1'b0);
        run_op(-32768,   -1, 8'h00, 8'h00, 1, 0, 0, 1'b0);
        run_op(  1000,    3, 8'h4D, 8'h01, 1, 0, 0, 1'b0);

        run_op(1234, 0, 8'h00, 8'h00, 0, 1, 0, 1'b0);
        run_op(   9, 3, 8'h03, 8'h00, 0, 0, 0, 1'b0);

        run_op( 100,  7, 8'h0E, 8'h02, 0, 0, 0,  1'b1);
        run_op(-100, -7, 8'h0E, 8'hFE, 0, 0, 10, 1'b0);

        // Abort an operation with reset on its 5th BUSY edge.
        A     = 16'd500;
        B     = 8'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_done", int'(done), 0);
        check("abort_Q", int'(Q), 0);
        check("abort_R", int'(R), 0);
        check("abort_ovf", int'(ovf), 0);
        check("abort_dz", int'(dz), 0);

        run_op(100, 7, 8'h0E, 8'h02, 0, 0, 0, 1'b0);

        check("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
